// File: rtl/tx_framer.sv
// Frame builder: preamble + 16-bit sync word + payload, with optional CRC-16/CCITT-FALSE trailer.
// Optional trailer is enabled by defining TX_FRAMER_CRC_EN.
`timescale 1ns/1ps

module tx_framer #(
  parameter int unsigned PREAMBLE_LEN  = 8,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter logic [15:0] SYNC_WORD     = 16'hD391
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  input  logic       cfg_enable,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

`ifdef TX_FRAMER_CRC_EN
  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAYLOAD, CRC} state_t;
`else
  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAYLOAD} state_t;
`endif

  state_t     state;
  logic [7:0] idx;
  logic       hs;

`ifdef TX_FRAMER_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic [7:0]  dd;
    logic        fb;
    r  = c;
    dd = d;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = r[15] ^ dd[7];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      dd = {dd[6:0], 1'b0};
    end
    return r;
  endfunction
`endif

  assign hs = out_valid && out_ready;

  // Header/trailer outputs decode straight from registered state; payload is a
  // zero-latency pass-through so it cannot be registered without adding latency.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: ;
      PREAMBLE: begin
        out_valid = 1'b1;
        out_data  = PREAMBLE_BYTE;
      end
      SYNC: begin
        out_valid = 1'b1;
        out_data  = idx[0] ? SYNC_WORD[7:0] : SYNC_WORD[15:8];
      end
      PAYLOAD: begin
        out_valid = in_valid;
        out_data  = in_data;
        in_ready  = out_ready;
`ifndef TX_FRAMER_CRC_EN
        out_last  = in_last;
`endif
      end
`ifdef TX_FRAMER_CRC_EN
      CRC: begin
        out_valid = 1'b1;
        out_data  = idx[0] ? crc[7:0] : crc[15:8];
        out_last  = idx[0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef TX_FRAMER_CRC_EN
      crc        <= '1;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_enable && in_valid) begin
            state <= PREAMBLE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (hs) begin
            if (idx == PRE_LAST) begin
              state <= SYNC;
              idx   <= '0;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        SYNC: begin
          if (hs) begin
`ifdef TX_FRAMER_CRC_EN
            crc <= '1;
`endif
            if (idx[0]) begin
              state <= PAYLOAD;
              idx   <= '0;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        PAYLOAD: begin
          if (hs) begin
`ifdef TX_FRAMER_CRC_EN
            crc <= crc_next(crc, in_data);
            if (in_last) begin
              state <= CRC;
              idx   <= '0;
            end
`else
            if (in_last) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
`endif
          end
        end
`ifdef TX_FRAMER_CRC_EN
        CRC: begin
          if (hs) begin
            if (idx[0]) begin
              state      <= IDLE;
              idx        <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// Directed self-checking bench for tx_framer; expectations follow TX_FRAMER_CRC_EN.
`timescale 1ns/1ps

module tb_tx_framer;

`ifdef TX_FRAMER_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       cfg_enable;
  logic       busy;
  logic       frame_done;

  tx_framer #(
    .PREAMBLE_LEN (8),
    .PREAMBLE_BYTE(8'h55),
    .SYNC_WORD    (16'hD391)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .cfg_enable(cfg_enable),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          last_hs_cyc = 0;
  int          last_gap = 0;
  logic        after_last = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        bp = 1'b0;
  logic        abort = 1'b0;
  logic [8:0]  obs_q[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  pkt[0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? ~out_ready : 1'b1;
    end
  end

  // Output monitor: collects beats, checks stall stability and frame_done timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (after_last) last_gap = cyc - last_hs_cyc;
        obs_q.push_back({out_last, out_data});
        last_hs_cyc = cyc;
        after_last  = out_last;
      end
      if (frame_done) begin
        fd_cnt++;
        check("done_timing", cyc - last_hs_cyc, 32'd1);
      end
    end
  end

  task automatic wait_accept(output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (abort) return;
      if (in_valid && in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        return;
      end
    end
    check("accept_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input int n, input int gap_at);
    logic ok;
    int   n0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        n0 = obs_q.size();
        repeat (5) @(posedge clk);
        #1;
        check("gap_quiet", obs_q.size(), n0);
      end
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == n - 1);
      wait_accept(ok);
      if (!ok) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_frame(input int n, input logic [15:0] crc);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD3});
    exp_q.push_back({1'b0, 8'h91});
    for (int i = 0; i < n; i++) exp_q.push_back({!CRC_EN && (i == n - 1), pkt[i]});
    if (CRC_EN) begin
      exp_q.push_back({1'b0, crc[15:8]});
      exp_q.push_back({1'b1, crc[7:0]});
    end
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_beats"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_frames(input int target);
    for (int t = 0; t < 1000 && fd_cnt < target; t++) @(negedge clk);
    check("frame_done_cnt", fd_cnt, target);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; cfg_enable = 1'b1;
    for (int i = 0; i < 16; i++) pkt[i] = 8'h31 + 8'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single frame, payload "123456789"
    fd_cnt = 0;
    expect_frame(9, 16'h29B1);
    send(9, -1);
    wait_frames(1);
    check("t1_total", obs_q.size(), CRC_EN ? 32'd21 : 32'd19);
    check_frames("t1");
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // backpressure
    fd_cnt = 0;
    bp = 1'b1;
    expect_frame(9, 16'h29B1);
    send(9, -1);
    wait_frames(1);
    bp = 1'b0;
    check_frames("t2");

    // in_valid gap mid-payload
    fd_cnt = 0;
    expect_frame(9, 16'h29B1);
    send(9, 4);
    wait_frames(1);
    check_frames("t3");

    // two back-to-back 1-byte frames of 0x00
    fd_cnt = 0;
    pkt[0] = 8'h00;
    expect_frame(1, 16'hE1F0);
    expect_frame(1, 16'hE1F0);
    send(1, -1);
    send(1, -1);
    wait_frames(2);
    check_frames("t4");
    check("b2b_gap", last_gap, 32'd2);
    pkt[0] = 8'h31;

    // cfg_enable dropped during SYNC
    fd_cnt = 0;
    expect_frame(9, 16'h29B1);
    fork
      send(9, -1);
      begin
        for (int t = 0; t < 300 && obs_q.size() < 9; t++) @(negedge clk);
        @(posedge clk);
        #1;
        cfg_enable = 1'b0;
      end
    join
    wait_frames(1);
    check_frames("t5");
    in_valid = 1'b1;
    in_data  = 8'h31;
    repeat (6) begin
      @(negedge clk);
      check("t5_in_ready", {31'd0, in_ready}, 32'd0);
    end
    check("t5_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    cfg_enable = 1'b1;
    @(posedge clk);
    #1;

    // async reset in PAYLOAD, then a clean frame
    fork
      send(9, -1);
      begin
        for (int t = 0; t < 300 && obs_q.size() < 13; t++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check("t6_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_in_ready", {31'd0, in_ready}, 32'd0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    abort = 1'b0;
    obs_q.delete();
    exp_q.delete();
    fd_cnt = 0;
    @(posedge clk);
    #1;
    expect_frame(9, 16'h29B1);
    send(9, -1);
    wait_frames(1);
    check_frames("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_framer.md
# tx_framer

Byte-stream frame builder that sits directly upstream of the byte scrambler in the TX datapath. It wraps each payload packet, delimited by `in_last`, with a fixed preamble and a 16-bit sync word, and optionally appends a CRC-16. Its output is a simple valid/ready byte stream that feeds the scrambler input port with no glue logic. `out_last` is provided for downstream sideband handling.

## Interface
Parameters:
- `PREAMBLE_LEN`, default 8: number of preamble bytes per frame; legal range 1..255.
- `PREAMBLE_BYTE`, default 8'h55: value of each preamble byte.
- `SYNC_WORD`, default 16'hD391: sync word; sent MSB byte first.

Ports:
- `clk`  in  1  single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  payload byte.
- `in_valid`  in  1  payload byte valid.
- `in_last`  in  1  marks the final payload byte of a packet.
- `in_ready`  out  1  payload byte accepted when `in_valid && in_ready`.
- `out_data`  out  8  framed byte, to scrambler `in_data`.
- `out_valid`  out  1  framed byte valid.
- `out_last`  out  1  final byte of the frame.
- `out_ready`  in  1  downstream ready, from scrambler `in_ready`.
- `cfg_enable`  in  1  allows new frames to start; sampled only in IDLE.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  1-cycle pulse on the handshake of the `out_last` byte.

## Operation
- **FSM states:** IDLE, PREAMBLE, SYNC, PAYLOAD, CRC.
- **IDLE**
  - Outputs: `in_ready`=0, `out_valid`=0.
  - If `cfg_enable && in_valid`, go to PREAMBLE and clear `idx`.
  - The pending payload byte is held upstream and is not consumed.
- **PREAMBLE**
  - Outputs: `out_valid`=1, `out_data`=`PREAMBLE_BYTE`.
  - `idx` increments on each output handshake.
  - On the handshake with `idx==PREAMBLE_LEN-1`, go to SYNC and clear `idx`.
- **SYNC**
  - Outputs: `out_valid`=1, `out_data`=`SYNC_WORD[15:8]`, then `SYNC_WORD[7:0]`.
  - After the second handshake, go to PAYLOAD.
  - Load the CRC register with 16'hFFFF.
- **PAYLOAD**
  - Zero-latency pass-through: `out_data`=`in_data`, `out_valid`=`in_valid`, `in_ready`=`out_ready`.
  - Each handshake folds `in_data` into the CRC.
  - A handshake with `in_last`=1 goes to CRC, or to IDLE when CRC is compiled out.
- **CRC**
  - Outputs: `out_valid`=1, `out_data`=`crc[15:8]`, then `crc[7:0]`.
  - After the second handshake, go to IDLE.
- **CRC algorithm:** CRC-16/CCITT-FALSE.
  - Polynomial 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Bytes are processed MSB-first.
  - An 8-step combinational update per accepted byte.
- **`out_valid` stability:** `out_valid` never drops while `out_ready`=0 in the PREAMBLE, SYNC and CRC states. In PAYLOAD it follows `in_valid`.
- **`cfg_enable` deasserted mid-frame:** the current frame completes and no new frame starts.
- **`in_valid` low during PAYLOAD:** the FSM waits and emits no filler bytes.
- **Reset mid-frame:** the FSM returns to IDLE, `idx`=0, and `crc`=16'hFFFF. The partial frame is abandoned; the downstream scrambler must be reseeded by software.
- **Reset values:** `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `frame_done`=0.

## Timing
- **Payload latency:** 0 cycles, combinational in to out.
- **Throughput:** 1 byte/cycle when `out_ready` is held high.
- **Per-frame overhead:** `PREAMBLE_LEN`+2 header cycles, +2 CRC cycles, +1 IDLE cycle.
- **Minimum gap:** exactly 1 cycle between the `out_last` handshake and the first preamble byte of the next frame.
- **Register updates:** `idx` is 8 bits wide. `idx`, `crc` and state update only on output handshakes.
- **`frame_done`:** registered; asserted the cycle after the final handshake.
- **`busy`:** high from the cycle after the IDLE exit until IDLE is re-entered.

## Configuration
- **Macro:** `TX_FRAMER_CRC_EN`.
- **Defined:**
  - The CRC state and the 16-bit CRC register are present.
  - `out_last` marks the CRC low byte.
- **Undefined:**
  - The CRC state and CRC register are removed.
  - The last payload byte goes straight to IDLE.
  - `out_last` equals `in_last` on that byte.

## Test plan
- **Single frame, CRC enabled:**
  - Stimulus: `PREAMBLE_LEN`=8, payload 0x31..0x39 with `in_last` on 0x39, `out_ready`=1.
  - Response: 8×0x55, 0xD3, 0x91, 0x31..0x39, 0x29, 0xB1. `out_last` on 0xB1, `frame_done` pulses once, 21 output beats total.
- **Backpressure:**
  - Stimulus: `out_ready` toggled every other cycle during PREAMBLE, SYNC and CRC.
  - Response: `out_data` holds stable while stalled, no byte is dropped or duplicated, and the CRC is still 0x29B1.
- **Idle gaps and back-to-back frames:**
  - Stimulus: `in_valid` low for 5 cycles mid-payload, then two back-to-back 1-byte frames (0x00).
  - Response: no output beats during the gap. Each 1-byte frame emits 0x00 followed by CRC 0xE1F0. Exactly 1 idle cycle separates the frames.
- **`cfg_enable` dropped mid-frame:**
  - Stimulus: `cfg_enable` deasserted during SYNC.
  - Response: the frame finishes, and `in_ready` stays 0 afterwards with `in_valid` held high.
- **Asynchronous reset mid-frame:**
  - Stimulus: `rst_n` asserted during PAYLOAD.
  - Response: `out_valid`=0 immediately, `busy`=0, and the next frame starts with a full preamble and a correct CRC.
- **CRC compiled out:**
  - Stimulus: build without `TX_FRAMER_CRC_EN` and send payload 0x31..0x39.
  - Response: the frame ends at 0x39 with `out_last` high, 19 output beats total.
